// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM state type and the bit-serial step and reflect helpers.
// Widths are carried as arguments so one function serves every CRC_W/DATA_W combination.
package crc_pkg;

  localparam int MAX_CRC_W  = 32;
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } crc_state_e;

  function automatic logic [MAX_CRC_W-1:0] crc_mask(input int crc_w);
    return {MAX_CRC_W{1'b1}} >> (MAX_CRC_W - crc_w);
  endfunction

  // DATA_W serial LFSR steps; the loop bound is fixed so synthesis fully unrolls it.
  function automatic logic [MAX_CRC_W-1:0] crc_step(
    input logic [MAX_CRC_W-1:0]  seed,
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_CRC_W-1:0]  poly,
    input int                    crc_w,
    input int                    data_w,
    input bit                    refin
  );
    logic [MAX_CRC_W-1:0] mask;
    logic [MAX_CRC_W-1:0] crc;
    logic                 din;
    logic                 fb;
    int                   idx;
    int                   top;
    mask = crc_mask(crc_w);
    crc  = seed & mask;
    top  = crc_w - 1;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        idx = refin ? i : (data_w - 1 - i);
        din = data[idx[5:0]];
        fb  = crc[top[4:0]] ^ din;
        crc = ((crc << 1) ^ (fb ? poly : {MAX_CRC_W{1'b0}})) & mask;
      end
    end
    return crc;
  endfunction

  function automatic logic [MAX_CRC_W-1:0] reflect(
    input logic [MAX_CRC_W-1:0] v,
    input int                   w
  );
    logic [MAX_CRC_W-1:0] r;
    int                   idx;
    r = {MAX_CRC_W{1'b0}};
    for (int i = 0; i < MAX_CRC_W; i++) begin
      if (i < w) begin
        idx      = w - 1 - i;
        r[i]     = v[idx[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_next.sv
// Combinational DATA_W-bit CRC update: one beat folded into the seed register value.
module crc_next
  import crc_pkg::*;
#(
  parameter int          CRC_W  = 16,
  parameter int          DATA_W = 8,
  parameter logic [31:0] POLY   = 32'h0000_8005,
  parameter bit          REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]  seed,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  result
);

  assign result = CRC_W'(crc_step(32'(seed), 64'(data), POLY, CRC_W, DATA_W, REFIN));

endmodule

// File: rtl/crc_engine.sv
// Stream-fed parametrised CRC generator with valid/ready input, first/last framing
// and a held result that is released to the sink on m_ready_i.
module crc_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W  = 16,
  parameter logic [31:0] POLY   = 32'h0000_8005,
  parameter logic [31:0] INIT   = 32'h0000_0000,
  parameter bit          REFIN  = 1'b0,
  parameter bit          REFOUT = 1'b0,
  parameter logic [31:0] XOROUT = 32'h0000_0000,
  parameter int          DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_first_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CRC_W-1:0]  m_crc_o,
  output logic [CRC_W-1:0]  crc_raw_o
);

  localparam logic [CRC_W-1:0] INIT_T   = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_T = XOROUT[CRC_W-1:0];

  crc_state_e       state_r;
  crc_state_e       state_nxt_s;
  logic [CRC_W-1:0] lfsr_r;
  logic [CRC_W-1:0] crc_out_r;
  logic             m_valid_r;
  logic [CRC_W-1:0] seed_s;
  logic [CRC_W-1:0] step_s;
  logic [CRC_W-1:0] final_s;
  logic             ready_s;
  logic             accept_s;

  // Ready drops only while a finished CRC waits; a same-cycle handoff keeps it high.
  assign ready_s  = (state_r != ST_HOLD) | m_ready_i;
  assign accept_s = s_valid_i & ready_s;

  // Seed selection: any beat outside an open frame, or flagged first, starts from INIT.
  always_comb begin
    seed_s = lfsr_r;
    if ((state_r != ST_RUN) || s_first_i) begin
      seed_s = INIT_T;
    end else begin
      seed_s = lfsr_r;
    end
  end

  crc_next #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_crc_next (
    .seed   (seed_s),
    .data   (s_data_i),
    .result (step_s)
  );

  // Output shaping of the post-beat register value.
  always_comb begin
    final_s = step_s ^ XOROUT_T;
    if (REFOUT) begin
      final_s = CRC_W'(reflect(32'(step_s), CRC_W)) ^ XOROUT_T;
    end else begin
      final_s = step_s ^ XOROUT_T;
    end
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = s_last_i ? ST_HOLD : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && s_last_i) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (!m_ready_i) begin
          state_nxt_s = ST_HOLD;
        end else if (accept_s) begin
          state_nxt_s = s_last_i ? ST_HOLD : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered result-valid flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      m_valid_r <= (state_nxt_s == ST_HOLD);
    end
  end

  // LFSR and result registers; the LFSR falls back to INIT when a result leaves with no new beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_r    <= INIT_T;
      crc_out_r <= {CRC_W{1'b0}};
    end else if (accept_s) begin
      lfsr_r <= step_s;
      if (s_last_i) begin
        crc_out_r <= final_s;
      end
    end else if ((state_r == ST_HOLD) && m_ready_i) begin
      lfsr_r <= INIT_T;
    end
  end

  assign s_ready_o = ready_s;
  assign m_valid_o = m_valid_r;
  assign m_crc_o   = crc_out_r;
  assign crc_raw_o = lfsr_r;

endmodule
